// File: rtl/axis_xscaler.sv
// Horizontal nearest-neighbour downscaler for AXI4-Stream video (error-accumulator decimation, 1 pixel/cycle).
// Optional XSCALER_AVG_EN: each emitted pixel is the rounded mean of itself and the previous pixel of its line.
module axis_xscaler #(
  parameter int C_PIXEL_WIDTH = 8,
  parameter int C_IMG_WBITS   = 12
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [C_IMG_WBITS-1:0]   ori_width,
  input  logic [C_IMG_WBITS-1:0]   scale_width,
  input  logic                     S_AXIS_tvalid,
  output logic                     S_AXIS_tready,
  input  logic [C_PIXEL_WIDTH-1:0] S_AXIS_tdata,
  input  logic                     S_AXIS_tuser,
  input  logic                     S_AXIS_tlast,
  output logic                     M_AXIS_tvalid,
  input  logic                     M_AXIS_tready,
  output logic [C_PIXEL_WIDTH-1:0] M_AXIS_tdata,
  output logic                     M_AXIS_tuser,
  output logic                     M_AXIS_tlast
);

  localparam int AW = C_IMG_WBITS + 1;

  logic [C_IMG_WBITS-1:0]   ow;
  logic [C_IMG_WBITS-1:0]   sw;
  logic [C_IMG_WBITS-1:0]   col;
  logic [AW-1:0]            acc;
  logic                     sof_pend;
  logic [C_PIXEL_WIDTH-1:0] prev;

  logic                     out_valid;
  logic [C_PIXEL_WIDTH-1:0] out_data;
  logic                     out_user;
  logic                     out_last;

  logic                     accept;
  logic [C_IMG_WBITS-1:0]   ow_cur;
  logic [C_IMG_WBITS-1:0]   sw_cur;
  logic [C_IMG_WBITS-1:0]   col_cur;
  logic [C_IMG_WBITS-1:0]   col_nxt;
  logic [AW-1:0]            a_sum;
  logic [AW-1:0]            acc_nxt;
  logic                     line_start;
  logic                     hit;
  logic                     over;
  logic                     emit;
  logic                     pend_cur;
  logic [C_PIXEL_WIDTH-1:0] pix;
  logic [C_PIXEL_WIDTH:0]   avg_sum;

  assign S_AXIS_tready = ~out_valid | M_AXIS_tready;
  assign accept        = S_AXIS_tvalid & S_AXIS_tready;

  assign M_AXIS_tvalid = out_valid;
  assign M_AXIS_tdata  = out_data;
  assign M_AXIS_tuser  = out_user;
  assign M_AXIS_tlast  = out_last;

  // An SOF pixel is processed with the widths it carries, not the stale latched ones.
  always_comb begin
    // NOTE: every signal gets a default first so no path through this block infers a latch.
    ow_cur = ow;
    sw_cur = sw;
    if (S_AXIS_tuser) begin
      ow_cur = ori_width;
      if (ori_width == '0 || scale_width == '0)
        sw_cur = ori_width;
      else if (scale_width < ori_width)
        sw_cur = scale_width;
      else
        sw_cur = ori_width;
    end

    col_cur    = S_AXIS_tuser ? '0 : col;
    line_start = (col_cur == '0);
    a_sum      = (line_start ? '0 : acc) + {1'b0, sw_cur};
    hit        = (a_sum >= {1'b0, ow_cur});
    acc_nxt    = hit ? (a_sum - {1'b0, ow_cur}) : a_sum;

    // ow==0 (never latched or zero width) means passthrough, so no long-line cut applies.
    over = (ow_cur != '0) && (col_cur >= ow_cur);
    emit = S_AXIS_tlast | (hit & ~over);

    pend_cur = sof_pend | S_AXIS_tuser;

    if (S_AXIS_tlast)
      col_nxt = '0;
    else if (col_cur == '1)
      col_nxt = col_cur;
    else
      col_nxt = col_cur + 1'b1;

    avg_sum = {1'b0, prev} + {1'b0, S_AXIS_tdata} + 1'b1;
`ifdef XSCALER_AVG_EN
    pix = line_start ? S_AXIS_tdata : avg_sum[C_PIXEL_WIDTH:1];
`else
    pix = S_AXIS_tdata;
`endif
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (reset) begin
      ow        <= '0;
      sw        <= '0;
      col       <= '0;
      acc       <= '0;
      sof_pend  <= 1'b0;
      prev      <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_user  <= 1'b0;
      out_last  <= 1'b0;
    end else begin
      if (accept) begin
        ow   <= ow_cur;
        sw   <= sw_cur;
        col  <= col_nxt;
        acc  <= acc_nxt;
        prev <= S_AXIS_tdata;
        sof_pend <= emit ? 1'b0 : pend_cur;
      end

      if (accept && emit) begin
        out_valid <= 1'b1;
        out_data  <= pix;
        out_user  <= pend_cur;
        out_last  <= S_AXIS_tlast;
      end else if (M_AXIS_tready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_axis_xscaler.sv
// Self-checking bench for axis_xscaler: directed test-plan cases plus randomized frames
// checked against a line-level reference model with random valid gaps and backpressure.
module tb_axis_xscaler;

  localparam int PW = 8;
  localparam int WB = 12;

  typedef struct {
    logic [PW-1:0] d;
    logic          u;
    logic          l;
  } beat_t;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [WB-1:0] ori = '0;
  logic [WB-1:0] scl = '0;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic [PW-1:0] s_data = '0;
  logic          s_user = 1'b0;
  logic          s_last = 1'b0;
  logic          m_valid;
  logic          m_ready = 1'b0;
  logic [PW-1:0] m_data;
  logic          m_user;
  logic          m_last;

  axis_xscaler #(.C_PIXEL_WIDTH(PW), .C_IMG_WBITS(WB)) dut (
    .clk           (clk),
    .reset         (reset),
    .ori_width     (ori),
    .scale_width   (scl),
    .S_AXIS_tvalid (s_valid),
    .S_AXIS_tready (s_ready),
    .S_AXIS_tdata  (s_data),
    .S_AXIS_tuser  (s_user),
    .S_AXIS_tlast  (s_last),
    .M_AXIS_tvalid (m_valid),
    .M_AXIS_tready (m_ready),
    .M_AXIS_tdata  (m_data),
    .M_AXIS_tuser  (m_user),
    .M_AXIS_tlast  (m_last)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  // Reference model: keeps column c of a line iff floor((c+1)*sw/ow) > floor(c*sw/ow).
  int    m_ow, m_sw, m_col, m_prev;
  bit    m_pend;
  beat_t in_q[$];
  beat_t exp_q[$];
  beat_t got_q[$];

  function automatic void model_reset();
    m_ow = 0; m_sw = 0; m_col = 0; m_prev = 0; m_pend = 1'b0;
    exp_q.delete();
  endfunction

  function automatic void model_beat(beat_t b);
    int    c, o, s;
    bit    keep;
    beat_t e;
    if (b.u) begin
      o = int'(ori);
      s = int'(scl);
      m_ow = o;
      m_sw = (o == 0 || s == 0) ? o : ((s < o) ? s : o);
      m_col = 0;
      m_pend = 1'b1;
    end
    c = m_col;
    if (m_ow == 0) keep = 1'b1;
    else keep = (c < m_ow) && (((c + 1) * m_sw) / m_ow > (c * m_sw) / m_ow);
    keep = keep | b.l;
    if (keep) begin
`ifdef XSCALER_AVG_EN
      e.d = (c == 0) ? b.d : PW'((m_prev + int'(b.d) + 1) / 2);
`else
      e.d = b.d;
`endif
      e.u = m_pend;
      e.l = b.l;
      exp_q.push_back(e);
      m_pend = 1'b0;
    end
    m_prev = int'(b.d);
    m_col  = b.l ? 0 : c + 1;
  endfunction

  task automatic push_beat(input int d, input bit u, input bit l);
    beat_t b;
    b.d = PW'(d); b.u = u; b.l = l;
    in_q.push_back(b);
  endtask

  // Line of n pixels with data base, base+step, ...; tuser on the first when sof is set.
  task automatic push_line(input int n, input int base, input int step, input bit sof);
    for (int i = 0; i < n; i++) push_beat(base + i * step, sof && i == 0, i == n - 1);
  endtask

  // Drives in_q into the DUT and checks every output beat against the model.
  task automatic run(input int vp, input int rp, input int budget);
    int    idx = 0, cycles = 0;
    bit    acc_prev = 1'b0, stall_prev = 1'b0;
    logic [31:0] snap = '0;
    beat_t e, g;
    got_q.delete();
    while ((idx < in_q.size() || exp_q.size() > 0) && cycles < budget) begin
      @(negedge clk);
      cycles++;
      if (stall_prev) check("stall_hold", {21'd0, m_valid, m_user, m_last, m_data}, snap);
      if (acc_prev) begin
        idx++;
        s_valid = 1'b0;
      end
      if (!s_valid && idx < in_q.size() && $urandom_range(99) < vp) begin
        s_valid = 1'b1;
        s_data  = in_q[idx].d;
        s_user  = in_q[idx].u;
        s_last  = in_q[idx].l;
      end
      m_ready = ($urandom_range(99) < rp);
      #1;
      acc_prev = s_valid && s_ready;
      if (acc_prev) model_beat(in_q[idx]);
      if (m_valid && m_ready) begin
        g.d = m_data; g.u = m_user; g.l = m_last;
        got_q.push_back(g);
        if (exp_q.size() == 0) check("extra_beat", 32'd1, 32'd0);
        else begin
          e = exp_q.pop_front();
          check("beat", {23'd0, g.u, g.l, g.d}, {23'd0, e.u, e.l, e.d});
        end
      end
      stall_prev = m_valid && !m_ready;
      snap = {21'd0, m_valid, m_user, m_last, m_data};
    end
    check("run_in_budget", 32'(cycles < budget), 32'd1);
    check("exp_drained", 32'(exp_q.size()), 32'd0);
    @(negedge clk);
    s_valid = 1'b0;
    m_ready = 1'b1;
    @(negedge clk);
    check("idle_after_run", 32'(m_valid), 32'd0);
    in_q.delete();
  endtask

  int dec_exp[4];

  initial begin
`ifdef XSCALER_AVG_EN
    dec_exp = '{15, 35, 65, 85};
`else
    dec_exp = '{20, 40, 70, 90};
`endif
    model_reset();
    repeat (2) @(negedge clk);
    check("rst_valid", 32'(m_valid), 32'd0);
    check("rst_data", 32'(m_data), 32'd0);
    check("rst_user_last", {30'd0, m_user, m_last}, 32'd0);
    check("rst_ready", 32'(s_ready), 32'd1);
    reset = 1'b0;

    // Decimation, full throughput.
    ori = 12'd10; scl = 12'd4;
    push_line(10, 0, 10, 1'b1);
    run(100, 100, 200);
    check("dec_count", 32'(got_q.size()), 32'd4);
    for (int i = 0; i < 4 && i < got_q.size(); i++)
      check($sformatf("dec_data%0d", i), 32'(got_q[i].d), 32'(dec_exp[i]));
    if (got_q.size() == 4) begin
      check("dec_sof", {31'd0, got_q[0].u}, 32'd1);
      check("dec_eol", {31'd0, got_q[3].l}, 32'd1);
    end

    // Passthrough: ow=sw=1, ten one-pixel lines.
    ori = 12'd1; scl = 12'd1;
    for (int i = 0; i < 10; i++) push_line(1, i * 10, 0, i == 0);
    run(100, 100, 200);
    check("pass_count", 32'(got_q.size()), 32'd10);

    // Passthrough via sw=0 and via sw>ow.
    ori = 12'd6; scl = 12'd0;
    push_line(6, 3, 7, 1'b1);
    run(100, 100, 200);
    check("pass_sw0_count", 32'(got_q.size()), 32'd6);
    ori = 12'd6; scl = 12'd9;
    push_line(6, 5, 11, 1'b1);
    run(100, 100, 200);
    check("pass_swbig_count", 32'(got_q.size()), 32'd6);

    // Backpressure.
    ori = 12'd10; scl = 12'd4;
    push_line(10, 0, 10, 1'b1);
    run(100, 50, 400);
    check("bp_count", 32'(got_q.size()), 32'd4);

    // Short line then a full line in the same frame.
    push_line(6, 0, 10, 1'b1);
    push_line(10, 100, 1, 1'b0);
    run(100, 100, 200);
    check("short_count", 32'(got_q.size()), 32'd7);
    if (got_q.size() == 7) begin
      check("short_last_data", 32'(got_q[2].d), 32'd50);
      check("short_last_eol", {31'd0, got_q[2].l}, 32'd1);
    end

    // Mid-line SOF at column 3, then the restarted line runs to its full width.
    for (int i = 0; i < 3; i++) push_beat(i * 10, i == 0, 1'b0);
    push_line(10, 200, 3, 1'b1);
    run(100, 100, 200);
    check("midsof_count", 32'(got_q.size()), 32'd5);
    if (got_q.size() == 5) check("midsof_user", {31'd0, got_q[1].u}, 32'd1);

    // Reset for one cycle while an output beat is stalled.
    @(negedge clk);
    ori = 12'd1; scl = 12'd1;
    m_ready = 1'b0;
    s_valid = 1'b1; s_data = 8'hA5; s_user = 1'b1; s_last = 1'b1;
    @(negedge clk);
    s_valid = 1'b0;
    check("rstmid_pre_valid", 32'(m_valid), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("rstmid_valid", 32'(m_valid), 32'd0);
    model_reset();
    ori = 12'd10; scl = 12'd4;
    push_line(10, 0, 10, 1'b1);
    run(100, 100, 200);
    if (got_q.size() > 0) check("rstmid_sof", {31'd0, got_q[0].u}, 32'd1);
    else check("rstmid_any_out", 32'd0, 32'd1);

    // Randomized frames: ragged line lengths, occasional mid-line SOF, random gaps and stalls.
    for (int f = 0; f < 12; f++) begin
      int nlines;
      ori = WB'($urandom_range(16, 1));
      scl = WB'($urandom_range(20, 0));
      nlines = $urandom_range(4, 1);
      for (int ln = 0; ln < nlines; ln++) begin
        int lo, len;
        lo  = (int'(ori) > 3) ? int'(ori) - 3 : 1;
        len = $urandom_range(int'(ori) + 3, lo);
        for (int i = 0; i < len; i++)
          push_beat($urandom_range(255, 0),
                    (ln == 0 && i == 0) || ($urandom_range(39, 0) == 0),
                    i == len - 1);
      end
      run(70, 60, 2000);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/axis_xscaler.md
# axis_xscaler

Horizontal nearest-neighbour downscaler for AXI4-Stream video, placed directly upstream of the vertical scaler (yscaler) in the scaling chain. It consumes lines of `ori_width` pixels and emits `scale_width` pixels per line. SOF (`tuser`) and EOL (`tlast`) framing is preserved, so yscaler receives lines that are already `scale_width` wide. Decimation uses an error accumulator: no divider, one pixel per cycle.

## Interface
- `C_PIXEL_WIDTH`, 8, bits per pixel (`tdata` width)
- `C_IMG_WBITS`, 12, width of the width/column registers

- `clk`  in  1  single clock
- `reset`  in  1  synchronous, active-high
- `ori_width`  in  C_IMG_WBITS  input line length; sampled at SOF
- `scale_width`  in  C_IMG_WBITS  output line length; sampled at SOF
- `S_AXIS_tvalid`  in  1  input pixel valid
- `S_AXIS_tready`  out  1  input accept
- `S_AXIS_tdata`  in  C_PIXEL_WIDTH  input pixel
- `S_AXIS_tuser`  in  1  start of frame
- `S_AXIS_tlast`  in  1  end of line
- `M_AXIS_tvalid`  out  1  output pixel valid
- `M_AXIS_tready`  in  1  downstream accept
- `M_AXIS_tdata`  out  C_PIXEL_WIDTH  output pixel
- `M_AXIS_tuser`  out  1  start of frame
- `M_AXIS_tlast`  out  1  end of line

## Operation
- Registers: `ow`/`sw` (latched widths), `acc` (C_IMG_WBITS+1 bits), `col` (input column), `sof_pend`, and the output register (data/user/last/valid).
- Width latch: on an accepted pixel with `tuser=1`, load `ow=ori_width` and `sw=min(scale_width, ori_width)`. If `scale_width==0` or `ori_width==0`, use `sw=ow` (passthrough). The pixel is processed with the new values. Also set `sof_pend=1`.
- Per accepted pixel:
  - `a = (first pixel of line ? 0 : acc) + sw`, where a line starts after `tlast` or with `tuser`.
  - keep if `a >= ow`; then `acc = a - ow`, otherwise `acc = a`.
  - `col` increments and clears on `tlast` or `tuser`.
- For a well-formed line exactly `sw` pixels are kept. The last pixel is always kept.
  - Example: ow=10, sw=4 keeps columns 2, 4, 7, 9.
- Forced keep: a pixel with `tlast=1` is always emitted with `M_AXIS_tlast=1`. This covers short lines.
- Long lines: pixels with `col >= ow` and `tlast=0` are dropped.
- Output `tuser` is set on the first emitted pixel while `sof_pend=1`; `sof_pend` then clears.
- `tuser` arriving mid-line restarts the line: `acc` and `col` clear and the widths are relatched. No flush occurs, and the pending output pixel is unaffected.
- Dropped pixels are consumed and produce no output beat.

## Timing
- `S_AXIS_tready = ~M_AXIS_tvalid | M_AXIS_tready` (combinational; single output stage).
- Kept pixel accepted in cycle N appears on `M_AXIS_*` in cycle N+1. Latency is 1.
- Throughput is 1 pixel/cycle with `M_AXIS_tready` held high.
- Output is held stable while `M_AXIS_tvalid & ~M_AXIS_tready`.
- `M_AXIS_tvalid` clears after handshake unless a new kept pixel is accepted in the same cycle.
- Reset clears all registers: `M_AXIS_tvalid/tuser/tlast/tdata=0`, `acc=0`, `col=0`, `sof_pend=0`, `ow=sw=0`.
  - A frame interrupted by reset is discarded.
  - Output resumes at the next `tuser`; pixels before it are processed with ow=sw=0, i.e. passthrough.

## Configuration
- `XSCALER_AVG_EN` defined: each emitted pixel is `(prev + cur + 1) >> 1`.
  - `prev` is the previous accepted input pixel of the same line.
  - A kept pixel at column 0 is emitted unchanged.
  - Adds one `C_PIXEL_WIDTH` register, updated on every accepted pixel.
- Undefined: emitted pixel is `cur` unchanged (pure nearest neighbour).

## Test plan
- **Decimation:** ow=10, sw=4, one line, data 0,10,…,90, tuser on first, tlast on last, ready=1.
  -> outputs 20,40,70,90; tuser on 20; tlast on 90.
  - With `XSCALER_AVG_EN`: 15,35,65,85.
- **Passthrough:** ow=1, sw=1, 10 lines, data 0,10,…,90.
  -> 10 beats identical to input, tuser on the first beat, tlast on every beat.
  - Also: sw=0 or sw>ow gives passthrough.
- **Backpressure:** ow=10, sw=4 with `M_AXIS_tready` random 50%.
  -> same 4 pixels in order, no loss or duplication, output stable while stalled.
- **Short line:** ow=10, sw=4, tlast on column 5 (data 0..50).
  -> outputs 20,40,50; tlast on 50; next line starts with acc=0.
- **Mid-line SOF:** tuser at column 3 of an ow=10, sw=4 line, then a full line.
  -> acc restarts; next emitted pixel carries tuser; the new line yields 4 pixels.
- **Reset mid-frame:** reset 1 cycle while `M_AXIS_tvalid=1`.
  -> next cycle `M_AXIS_tvalid=0`; first output after the next tuser has tuser=1.
